// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the dcache and line-wide data memory: queues dirty lines, forwards reads
// from buffered lines, drains in order. Define WBB_COALESCE_EN to merge writes to an already-buffered line.
module dcache_wb_buffer #(
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cache_enable_i,
   input  logic         cache_write_i,
   input  logic [31:0]  cache_addr_i,
   input  logic [255:0] cache_data_i,
   output logic         cache_ack_o,
   output logic [255:0] cache_data_o,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic         mem_ack_i,
   input  logic [255:0] mem_data_i,
   output logic [3:0]   wbb_count_o,
   output logic         wbb_full_o
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, READ = 2'd2} state_t;

   state_t           r_state;
   logic [26:0]      r_line [DEPTH];
   logic [255:0]     r_data [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PW-1:0]    r_wptr, r_rptr;
   logic [3:0]       r_count;
   logic             r_rd_pend;
   logic [26:0]      r_rd_line;
   logic             r_ack;
   logic [255:0]     r_rdata;
   logic             r_men, r_mwr;
   logic [31:0]      r_maddr;
   logic [255:0]     r_mdata;

   logic [26:0]      w_line;
   logic             w_req, w_full, w_pop, w_push, w_coal;
   logic             w_rd_hit, w_rd_fwd, w_rd_miss, w_rd_done;
   logic [PW-1:0]    w_rd_idx;
`ifdef WBB_COALESCE_EN
   logic             w_wr_hit;
   logic [PW-1:0]    w_wr_idx;
`endif
   logic             w_unused_addr;

   assign w_line        = cache_addr_i[31:5];
   assign w_unused_addr = ^cache_addr_i[4:0];
   // The ack cycle and a pending read miss both belong to a request already taken.
   assign w_req     = cache_enable_i && !r_ack && !r_rd_pend;
   assign w_full    = (r_count == 4'(DEPTH));
   assign w_pop     = (r_state == DRAIN) && mem_ack_i;
   assign w_rd_done = (r_state == READ) && mem_ack_i;

   // Scan oldest to newest so the last match is the newest copy of the line.
   always_comb begin : match
      logic [PW-1:0] w_idx;
      w_rd_hit = 1'b0;
      w_rd_idx = '0;
`ifdef WBB_COALESCE_EN
      w_wr_hit = 1'b0;
      w_wr_idx = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rptr + PW'(k);
         if (r_vld[w_idx] && r_line[w_idx] == w_line) begin
            if (!(w_idx == r_rptr && w_pop)) begin
               w_rd_hit = 1'b1;
               w_rd_idx = w_idx;
            end
`ifdef WBB_COALESCE_EN
            if (!(w_idx == r_rptr && r_state == DRAIN)) begin
               w_wr_hit = 1'b1;
               w_wr_idx = w_idx;
            end
`endif
         end
      end
   end

`ifdef WBB_COALESCE_EN
   assign w_coal = w_req && cache_write_i && w_wr_hit;
`else
   assign w_coal = 1'b0;
`endif
   // A full buffer still takes a write in the cycle the head pops.
   assign w_push    = w_req && cache_write_i && !w_coal && (!w_full || w_pop);
   assign w_rd_fwd  = w_req && !cache_write_i && w_rd_hit;
   assign w_rd_miss = w_req && !cache_write_i && !w_rd_hit;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_line[r_wptr] <= w_line;
         r_data[r_wptr] <= cache_data_i;
      end
`ifdef WBB_COALESCE_EN
      if (w_coal) r_data[w_wr_idx] <= cache_data_i;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= IDLE;
         r_vld     <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_rd_pend <= 1'b0;
         r_rd_line <= '0;
         r_ack     <= 1'b0;
         r_rdata   <= '0;
         r_men     <= 1'b0;
         r_mwr     <= 1'b0;
         r_maddr   <= '0;
         r_mdata   <= '0;
      end else begin
         r_ack   <= w_push || w_coal || w_rd_fwd || w_rd_done;
         r_rdata <= w_rd_fwd ? r_data[w_rd_idx] : (w_rd_done ? mem_data_i : '0);
         r_count <= r_count + 4'(w_push) - 4'(w_pop);
         if (w_pop) begin
            r_vld[r_rptr] <= 1'b0;
            r_rptr        <= r_rptr + PW'(1);
         end
         if (w_push) begin
            r_vld[r_wptr] <= 1'b1;
            r_wptr        <= r_wptr + PW'(1);
         end
         if (w_rd_miss) begin
            r_rd_pend <= 1'b1;
            r_rd_line <= w_line;
         end else if (w_rd_done) begin
            r_rd_pend <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (r_rd_pend) begin
                  r_state <= READ;
                  r_men   <= 1'b1;
                  r_mwr   <= 1'b0;
                  r_maddr <= {r_rd_line, 5'b0};
               end else if (r_count != 4'd0) begin
                  r_state <= DRAIN;
                  r_men   <= 1'b1;
                  r_mwr   <= 1'b1;
                  r_maddr <= {r_line[r_rptr], 5'b0};
                  r_mdata <= r_data[r_rptr];
               end
            end
            DRAIN, READ: begin
               if (mem_ack_i) begin
                  r_state <= IDLE;
                  r_men   <= 1'b0;
                  r_mwr   <= 1'b0;
                  r_maddr <= '0;
                  r_mdata <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cache_ack_o  = r_ack;
   assign cache_data_o = r_rdata;
   assign mem_enable_o = r_men;
   assign mem_write_o  = r_mwr;
   assign mem_addr_o   = r_maddr;
   assign mem_data_o   = r_mdata;
   assign wbb_count_o  = r_count;
   assign wbb_full_o   = w_full;
endmodule

// File: doc/dcache_wb_buffer.md
DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 256-bit write-back entries (power of 2, 2..8).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cache_enable_i, input, 1 bit: request from the dcache.
REQ-005 SHALL have port cache_write_i, input, 1 bit: 1 = write-back line, 0 = line fill read.
REQ-006 SHALL have port cache_addr_i, input, 32 bits: byte address; line = addr[31:5].
REQ-007 SHALL have port cache_data_i, input, 256 bits: write line.
REQ-008 SHALL have port cache_ack_o, output, 1 bit: one-cycle completion pulse to the dcache.
REQ-009 SHALL have port cache_data_o, output, 256 bits: read line, valid while cache_ack_o is high.
REQ-010 SHALL have port mem_enable_o, output, 1 bit: request to data memory.
REQ-011 SHALL have port mem_write_o, output, 1 bit: memory write.
REQ-012 SHALL have port mem_addr_o, output, 32 bits: memory address, with [4:0] forced to 0.
REQ-013 SHALL have port mem_data_o, output, 256 bits: memory write line.
REQ-014 SHALL have port mem_ack_i, input, 1 bit: one-cycle completion pulse from memory.
REQ-015 SHALL have port mem_data_i, input, 256 bits: memory read line, valid with mem_ack_i.
REQ-016 SHALL have port wbb_count_o, output, 4 bits: number of occupied entries.
REQ-017 SHALL have port wbb_full_o, output, 1 bit: high when wbb_count_o equals DEPTH.

Function
REQ-018 SHALL sample an upstream request at a posedge when cache_enable_i=1, except in a cycle where cache_ack_o=1; these cycles SHALL be ignored.
REQ-019 SHALL raise cache_ack_o for exactly one cycle per request; the dcache holds addr and data stable until it sees the ack.
REQ-020 For a write that is not full: SHALL store {line, data} at the FIFO tail and assert cache_ack_o in the next cycle.
REQ-021 For a write while full: SHALL withhold cache_ack_o until an entry frees, then accept it in the first cycle it can.
REQ-022 For a read whose line matches a buffered entry: SHALL return the newest matching entry's data with cache_ack_o in the next cycle, and SHALL NOT issue a memory access.
REQ-023 For a read with no match: SHALL issue a memory read and assert cache_ack_o, with cache_data_o set to the captured mem_data_i, in the cycle after mem_ack_i.
REQ-024 The downstream FSM SHALL have three states: IDLE, DRAIN and READ.
 - IDLE->READ: a read miss is pending (reads have priority).
 - IDLE->DRAIN: no read is pending and count>0.
 - DRAIN/READ->IDLE: on mem_ack_i.
REQ-025 In DRAIN: SHALL hold mem_enable_o=1, mem_write_o=1, and the head address and data stable until mem_ack_i, then pop the head.
REQ-026 SHALL allow at most one outstanding memory request; the FIFO SHALL drain in arrival order.
REQ-027 On a simultaneous push and pop in one cycle: count SHALL be unchanged and both pointers SHALL advance modulo DEPTH.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-029 Forwarding compare SHALL NOT include the head entry while it is in DRAIN after mem_ack_i; the popped entry is no longer valid.

Reset
REQ-030 On rst_i=0: all entries SHALL be invalidated, pointers and count SHALL be 0, FSM SHALL go to IDLE, and all outputs SHALL be 0, immediately and asynchronously.
REQ-031 Reset mid-drain SHALL discard the in-flight write; memory is left unmodified by the block.

Configuration
REQ-032 Macro WBB_COALESCE_EN.
 - Defined: a write whose line matches a valid entry (other than a head in DRAIN) SHALL overwrite that entry in place, with ack next cycle and count unchanged, even when full.
 - Undefined: every write SHALL append as a new entry.

Verification
REQ-033 Write line 0x00000200, data A, into an empty buffer -> ack at cycle +1, count=1, then mem write to 0x200 with data A, then count=0.
REQ-034 Write 0x200 then read 0x200 before the drain completes -> read ack +1 cycle with data A, and no mem read issued.
REQ-035 Five writes with DEPTH=4 and memory ack delayed 10 cycles -> fifth ack withheld until the first drain ack; wbb_full_o=1 meanwhile.
REQ-036 Read 0x400 with one write pending -> mem read 0x400 issued before the drain; ack with mem_data_i (0x0000_1001...F00F).
REQ-037 WBB_COALESCE_EN defined: write 0x200 with data A, then 0x200 with data B while the memory is stalled -> count=1 and the drain writes B; undefined -> count=2 and the drains write A then B.
REQ-038 Assert rst_i low during DRAIN with count=3 -> all outputs 0 and count=0 at once; no mem_enable_o after release until a new request.
